seg7_readback_checker: RTL and testbench
========================================

# seg7_readback_checker

Readback monitor for the seven-segment display bus: samples a 7-bit segment pattern, waits for it to be stable, decodes it back to a hex digit and checks that successive digits advance by exactly one (mod 16). It sits on the far side of the display driver, either on-chip or fed from `ui_in`. It turns the display into a self-checking observation point and reports decoded digits, illegal patterns and sequence errors.

## Interface
- `STABLE_CYCLES`, default 16: number of consecutive synchronized cycles a pattern must hold before it is accepted; legal range 1..255.
- `ERR_CNT_W`, default 8: width of the saturating error counter.

- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `seg_in`  in  7  segment pattern `{g,f,e,d,c,b,a}`, active-high, asynchronous to `clk`.
- `clear_errs`  in  1  synchronous clear of `err_count`.
- `digit_out`  out  4  last accepted decoded digit.
- `digit_valid`  out  1  one-cycle pulse when a new digit is accepted.
- `code_err`  out  1  one-cycle pulse when an accepted pattern is not a legal code.
- `seq_err`  out  1  one-cycle pulse when an accepted digit is not the previous digit + 1 mod 16.
- `err_count`  out  `ERR_CNT_W`  saturating count of `code_err` and `seq_err` events.
- `locked`  out  1  high while a reference digit is held.

## Operation
- **Code table** (hex, bit 6 = g). Every other nonzero pattern is illegal.
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07.
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
  - 00 = blank.
- **Front end**
  - Two-flop synchronizer on `seg_in`.
  - A candidate register plus a stability counter follow the synchronized pattern.
  - Any change in the pattern reloads the candidate and zeroes the counter.
- **Acceptance**
  - A candidate is accepted once it has held for `STABLE_CYCLES` cycles and differs from the last accepted pattern.
  - Each pattern is accepted once per appearance.
  - Glitches shorter than `STABLE_CYCLES` never produce an event.
  - After a glitch, the return to the same pattern produces no event.
- **State machine**, two states: UNLOCKED and LOCKED.
- **Action on acceptance of pattern P**
  - P = 00 (blank): no pulse, go to UNLOCKED, `digit_out` holds its value.
  - P illegal: `code_err` pulses and `err_count` increments. State, `digit_out` and the reference digit are unchanged.
  - P legal with digit d, in UNLOCKED: `digit_out` <= d, `digit_valid` pulses, go to LOCKED. No sequence check is made.
  - P legal with digit d, in LOCKED: `digit_out` <= d and `digit_valid` pulses. If d != (previous d + 1) mod 16, `seq_err` pulses in the same cycle and `err_count` increments. The reference becomes d in either case. F -> 0 is a legal advance.
- **Error counter**
  - `err_count` saturates at all-ones.
  - At most one increment per cycle; `code_err` and `seq_err` are mutually exclusive.
  - `clear_errs` zeroes it on the next edge and wins over a coincident increment.

## Timing
- **Reset values**
  - `digit_out`=0, `digit_valid`=0, `code_err`=0, `seq_err`=0, `err_count`=0, `locked`=0.
  - Synchronizer, candidate and last-accepted pattern are 00; stability counter is 0.
- **Latency**
  - `seg_in` changes before edge k and is then held.
  - The pulse (`digit_valid`, `code_err` or `seq_err`) is high exactly in the cycle after edge k+1+`STABLE_CYCLES`, i.e. it is registered on edge k+2+`STABLE_CYCLES`.
  - `digit_out` and `locked` update on that same edge.
- **Output registration**
  - All outputs are registered; pulses last exactly one cycle.
  - Minimum spacing between events is `STABLE_CYCLES`+1 cycles.
- **Reset mid-operation:** in-flight candidates are discarded and no pulse is emitted on the reset edge or the edge after it.
- **Stability counter:** width is the minimum needed to hold `STABLE_CYCLES`; it saturates and never wraps.

## Test plan
- **Counting sequence:** with `STABLE_CYCLES`=4, drive 3F, 06, 5B each held 20 cycles.
  - `digit_valid` pulses 3 times with `digit_out` 0, 1, 2.
  - First pulse exactly 6 cycles after the first change.
  - `locked` rises with the first pulse; `seq_err` stays 0.
- **Wrap:** drive 79 (E), 71 (F), 3F (0).
  - No `seq_err`; `digit_out` ends at 0.
  - Then drive 4F (3): `seq_err` pulses once with `digit_valid`, `err_count`=1.
- **Glitch rejection:** hold 06 (1), insert 7F for 3 cycles (`STABLE_CYCLES`=4), return to 06.
  - No pulses of any kind.
- **Illegal code:** from `digit_out`=2, drive 01.
  - `code_err` pulses, `err_count`+1, `digit_out` stays 2.
  - Then drive 4F (3): no `seq_err`.
- **Blank:** drive 00, then 6D (5).
  - Blank gives no pulse and `locked`=0.
  - 5 gives `digit_valid`, no `seq_err`, and `locked`=1.
- **Saturation, clear and reset:**
  - `ERR_CNT_W`=2: force 5 `seq_err` events; `err_count` reads 3.
  - Assert `clear_errs` coincident with a sixth error: `err_count`=0.
  - Assert `reset` mid-stability-window: all outputs return to reset values and no pulse follows.

Source files
------------

// File: rtl/seg7_readback_checker.sv
// -----------------------------------------------------------------------------
// seg7_readback_checker
//
// Watches a seven-segment bus from the far side of the display driver. The
// raw pattern is synchronized, debounced by a stability window, decoded back
// to a hex digit and checked for a +1 (mod 16) advance over the previous
// accepted digit.
//
// Parameters
//   STABLE_CYCLES : synchronized cycles a pattern must hold to be accepted
//                   (1..255)
//   ERR_CNT_W     : width of the saturating error counter
//
// Ports
//   clk         in   clock
//   reset       in   synchronous, active-high reset
//   seg_in      in   {g,f,e,d,c,b,a}, active-high, asynchronous to clk
//   clear_errs  in   zeroes err_count on the next edge (beats an increment)
//   digit_out   out  last accepted decoded digit
//   digit_valid out  one-cycle pulse when a new digit is accepted
//   code_err    out  one-cycle pulse when an accepted pattern is illegal
//   seq_err     out  one-cycle pulse when an accepted digit is not prev+1
//   err_count   out  saturating count of code_err and seq_err events
//   locked      out  high while a reference digit is held
// -----------------------------------------------------------------------------
module seg7_readback_checker #(
  parameter int STABLE_CYCLES = 16,
  parameter int ERR_CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           seg_in,
  input  logic                 clear_errs,
  output logic [3:0]           digit_out,
  output logic                 digit_valid,
  output logic                 code_err,
  output logic                 seq_err,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 locked
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_SAT    = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ACCEPT = CNT_W'(STABLE_CYCLES - 1);

  localparam logic [0:0] ST_UNLOCKED = 1'b0;
  localparam logic [0:0] ST_LOCKED   = 1'b1;

  // Legal codes packed with digit 0 in the least significant 7 bits.
  localparam logic [111:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  logic [6:0]           sync1_q, sync2_q;
  logic [6:0]           cand_q, cand_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [6:0]           last_q, last_d;
  logic [0:0]           state_q, state_d;
  logic [3:0]           digit_q, digit_d;
  logic                 valid_q, valid_d;
  logic                 code_err_q, code_err_d;
  logic                 seq_err_q, seq_err_d;
  logic [ERR_CNT_W-1:0] err_q, err_d;

  logic [15:0] code_hit;
  logic        dec_legal;
  logic [3:0]  dec_digit;
  logic        accept;

  // One comparator per legal code; at most one can hit.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_decode
      assign code_hit[gi] = (cand_q == SEG_TABLE[gi*7 +: 7]);
    end
  endgenerate

  always_comb begin
    dec_legal = |code_hit;
    dec_digit = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (code_hit[i]) begin
        dec_digit = 4'(i);
      end
    end
  end

  // Stability window: the counter restarts on every change of the
  // synchronized pattern and saturates, so a held pattern crosses the
  // acceptance point exactly once per appearance.
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (cnt_q != CNT_SAT) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Fires on the edge where the counter reaches STABLE_CYCLES. Comparing with
  // the last accepted pattern suppresses an event when a glitch returns to
  // the pattern that was already showing.
  assign accept = (sync2_q == cand_q) && (cnt_q == CNT_ACCEPT) &&
                  (cand_q != last_q);

  always_comb begin
    last_d     = last_q;
    state_d    = state_q;
    digit_d    = digit_q;
    valid_d    = 1'b0;
    code_err_d = 1'b0;
    seq_err_d  = 1'b0;
    if (accept) begin
      last_d = cand_q;
      if (cand_q == 7'h00) begin
        // Blank drops the reference but keeps the displayed digit.
        state_d = ST_UNLOCKED;
      end else if (!dec_legal) begin
        code_err_d = 1'b1;
      end else begin
        digit_d = dec_digit;
        valid_d = 1'b1;
        state_d = ST_LOCKED;
        // digit_q is the reference while locked; 4-bit add wraps F -> 0.
        if (state_q == ST_LOCKED && dec_digit != digit_q + 4'd1) begin
          seq_err_d = 1'b1;
        end
      end
    end
  end

  always_comb begin
    err_d = err_q;
    if (clear_errs) begin
      err_d = '0;
    end else if ((code_err_d || seq_err_d) && (err_q != '1)) begin
      err_d = err_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= 7'h00;
      sync2_q    <= 7'h00;
      cand_q     <= 7'h00;
      cnt_q      <= '0;
      last_q     <= 7'h00;
      state_q    <= ST_UNLOCKED;
      digit_q    <= 4'd0;
      valid_q    <= 1'b0;
      code_err_q <= 1'b0;
      seq_err_q  <= 1'b0;
      err_q      <= '0;
    end else begin
      sync1_q    <= seg_in;
      sync2_q    <= sync1_q;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      state_q    <= state_d;
      digit_q    <= digit_d;
      valid_q    <= valid_d;
      code_err_q <= code_err_d;
      seq_err_q  <= seq_err_d;
      err_q      <= err_d;
    end
  end

  assign digit_out   = digit_q;
  assign digit_valid = valid_q;
  assign code_err    = code_err_q;
  assign seq_err     = seq_err_q;
  assign err_count   = err_q;
  assign locked      = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_seg7_readback_checker.sv
// -----------------------------------------------------------------------------
// tb_seg7_readback_checker
//
// Drives segment patterns into seg7_readback_checker and compares every cycle
// against a behavioural model that works from the sampled input history:
// a pattern is accepted when it was sampled on STABLE_CYCLES+1 consecutive
// edges ending two edges ago, preceded by a different sample, and differs from
// the last accepted pattern. Scenario tasks add fixed expectations.
// -----------------------------------------------------------------------------
module tb_seg7_readback_checker;
  localparam int S  = 4;
  localparam int W  = 2;
  localparam int VW = 4 + 3 + W + 1;

  logic         clk = 1'b0;
  logic         reset;
  logic [6:0]   seg_in;
  logic         clear_errs;
  logic [3:0]   digit_out;
  logic         digit_valid;
  logic         code_err;
  logic         seq_err;
  logic [W-1:0] err_count;
  logic         locked;

  always #5 clk = ~clk;

  seg7_readback_checker #(.STABLE_CYCLES(S), .ERR_CNT_W(W)) dut (
    .clk(clk), .reset(reset), .seg_in(seg_in), .clear_errs(clear_errs),
    .digit_out(digit_out), .digit_valid(digit_valid), .code_err(code_err),
    .seq_err(seq_err), .err_count(err_count), .locked(locked)
  );

  int total = 0;
  int bad   = 0;

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model state
  logic [6:0] m_hist [S+4];
  logic [6:0] m_last;
  logic [3:0] m_digit;
  logic       m_dv, m_ce, m_se, m_locked;
  int         m_err;

  function automatic int decode(input logic [6:0] p);
    for (int i = 0; i < 16; i++) if (seg_tab[i] == p) return i;
    return -1;
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    return {m_digit, m_dv, m_ce, m_se, W'(m_err), m_locked};
  endfunction

  function automatic logic [VW-1:0] obs_vec();
    return {digit_out, digit_valid, code_err, seq_err, err_count, locked};
  endfunction

  // One clock edge: advance the model with the inputs present at the edge,
  // then wait 1 time unit so DUT outputs can be sampled.
  task automatic step();
    logic [6:0] p;
    bit         run;
    bit         inc;
    int         d;
    @(posedge clk);
    if (reset) begin
      for (int j = 0; j < S + 4; j++) m_hist[j] = 7'h00;
      m_last = 7'h00; m_digit = 4'd0; m_dv = 0; m_ce = 0; m_se = 0;
      m_locked = 0; m_err = 0;
    end else begin
      for (int j = S + 3; j > 0; j--) m_hist[j] = m_hist[j-1];
      m_hist[0] = seg_in;
      m_dv = 0; m_ce = 0; m_se = 0; inc = 0;
      p = m_hist[2];
      run = 1;
      for (int j = 3; j <= S + 2; j++) if (m_hist[j] != p) run = 0;
      if (run && m_hist[S+3] != p && p != m_last) begin
        m_last = p;
        d = decode(p);
        if (p == 7'h00) begin
          m_locked = 0;
        end else if (d < 0) begin
          m_ce = 1; inc = 1;
        end else begin
          if (m_locked && d != (int'(m_digit) + 1) % 16) begin
            m_se = 1; inc = 1;
          end
          m_digit = 4'(d); m_dv = 1; m_locked = 1;
        end
      end
      if (clear_errs) m_err = 0;
      else if (inc && m_err < (1 << W) - 1) m_err++;
    end
    #1;
  endtask

  task automatic log_evt(input string tag);
    if (digit_valid || code_err || seq_err)
      $display("txn %s seg=%h digit=%0d dv=%0b ce=%0b se=%0b err=%0d locked=%0b",
               tag, seg_in, digit_out, digit_valid, code_err, seq_err, err_count, locked);
  endtask

  task automatic test_reset();
    reset = 1; seg_in = 7'h00; clear_errs = 0;
    repeat (3) step();
    total++;
    if (obs_vec() !== '0) begin
      bad++; $display("FAIL reset_values obs=%h req=0", obs_vec());
    end
    reset = 0;
    repeat (3) begin
      step();
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL reset_idle obs=%h req=%h", obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_counting();
    logic [6:0] pats [3] = '{7'h3F, 7'h06, 7'h5B};
    logic [3:0] digs [$];
    int dv_n = 0, se_n = 0, first = -1, cyc = 0;
    for (int p = 0; p < 3; p++) begin
      seg_in = pats[p];
      repeat (20) begin
        step();
        total++;
        if (obs_vec() !== exp_vec()) begin
          bad++; $display("FAIL counting_cycle obs=%h req=%h", obs_vec(), exp_vec());
        end
        log_evt("count");
        if (digit_valid) begin
          dv_n++; digs.push_back(digit_out);
          if (first < 0) first = cyc;
        end
        if (seq_err) se_n++;
        cyc++;
      end
    end
    total++;
    if (dv_n !== 3) begin bad++; $display("FAIL counting_pulses got=%0d req=3", dv_n); end
    total++;
    if (digs.size() != 3 || digs[0] !== 4'd0 || digs[1] !== 4'd1 || digs[2] !== 4'd2) begin
      bad++; $display("FAIL counting_digits got=%p req=0,1,2", digs);
    end
    total++;
    if (first !== S + 2) begin bad++; $display("FAIL counting_latency got=%0d req=%0d", first, S + 2); end
    total++;
    if (se_n !== 0 || locked !== 1'b1) begin
      bad++; $display("FAIL counting_lock se=%0d locked=%0b req se=0 locked=1", se_n, locked);
    end
  endtask

  task automatic test_wrap();
    logic [6:0] pats [5] = '{7'h00, 7'h79, 7'h71, 7'h3F, 7'h4F};
    int se_n = 0, se_wo_dv = 0;
    for (int p = 0; p < 5; p++) begin
      seg_in = pats[p];
      if (p == 4) begin
        total++;
        if (se_n !== 0 || digit_out !== 4'd0) begin
          bad++; $display("FAIL wrap_f_to_0 se=%0d digit=%0d req se=0 digit=0", se_n, digit_out);
        end
      end
      repeat (20) begin
        step();
        total++;
        if (obs_vec() !== exp_vec()) begin
          bad++; $display("FAIL wrap_cycle obs=%h req=%h", obs_vec(), exp_vec());
        end
        log_evt("wrap");
        if (seq_err) se_n++;
        if (seq_err && !digit_valid) se_wo_dv++;
      end
    end
    total++;
    if (se_n !== 1 || se_wo_dv !== 0 || err_count !== W'(1)) begin
      bad++; $display("FAIL wrap_skip se=%0d lone=%0d err=%0d req se=1 lone=0 err=1",
                      se_n, se_wo_dv, err_count);
    end
  endtask

  task automatic test_glitch();
    int pulses = 0;
    clear_errs = 1; step(); clear_errs = 0;
    seg_in = 7'h06;
    repeat (20) begin
      step();
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL glitch_setup obs=%h req=%h", obs_vec(), exp_vec());
      end
      log_evt("glitch");
    end
    for (int n = 0; n < 23; n++) begin
      seg_in = (n < 3) ? 7'h7F : 7'h06;
      step();
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL glitch_cycle obs=%h req=%h", obs_vec(), exp_vec());
      end
      log_evt("glitch");
      if (digit_valid || code_err || seq_err) pulses++;
    end
    total++;
    if (pulses !== 0) begin bad++; $display("FAIL glitch_pulses got=%0d req=0", pulses); end
  endtask

  task automatic test_illegal();
    int ce_n = 0, se_n = 0;
    clear_errs = 1; step(); clear_errs = 0;
    seg_in = 7'h5B;
    repeat (20) step();
    total++;
    if (digit_out !== 4'd2) begin bad++; $display("FAIL illegal_setup digit=%0d req=2", digit_out); end
    seg_in = 7'h01;
    repeat (20) begin
      step();
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL illegal_cycle obs=%h req=%h", obs_vec(), exp_vec());
      end
      log_evt("illegal");
      if (code_err) ce_n++;
    end
    total++;
    if (ce_n !== 1 || err_count !== W'(1) || digit_out !== 4'd2) begin
      bad++; $display("FAIL illegal_code ce=%0d err=%0d digit=%0d req ce=1 err=1 digit=2",
                      ce_n, err_count, digit_out);
    end
    seg_in = 7'h4F;
    repeat (20) begin
      step();
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL illegal_next obs=%h req=%h", obs_vec(), exp_vec());
      end
      log_evt("illegal");
      if (seq_err) se_n++;
    end
    total++;
    if (se_n !== 0 || digit_out !== 4'd3) begin
      bad++; $display("FAIL illegal_resume se=%0d digit=%0d req se=0 digit=3", se_n, digit_out);
    end
  endtask

  task automatic test_blank();
    int pulses = 0, dv_n = 0, se_n = 0;
    seg_in = 7'h00;
    repeat (20) begin
      step();
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL blank_cycle obs=%h req=%h", obs_vec(), exp_vec());
      end
      if (digit_valid || code_err || seq_err) pulses++;
    end
    total++;
    if (pulses !== 0 || locked !== 1'b0 || digit_out !== 4'd3) begin
      bad++; $display("FAIL blank_unlock pulses=%0d locked=%0b digit=%0d req 0,0,3",
                      pulses, locked, digit_out);
    end
    seg_in = 7'h6D;
    repeat (20) begin
      step();
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL blank_relock obs=%h req=%h", obs_vec(), exp_vec());
      end
      log_evt("blank");
      if (digit_valid) dv_n++;
      if (seq_err) se_n++;
    end
    total++;
    if (dv_n !== 1 || se_n !== 0 || locked !== 1'b1 || digit_out !== 4'd5) begin
      bad++; $display("FAIL blank_five dv=%0d se=%0d locked=%0b digit=%0d req 1,0,1,5",
                      dv_n, se_n, locked, digit_out);
    end
  endtask

  task automatic test_saturation();
    logic [6:0] pats [5] = '{7'h3F, 7'h5B, 7'h3F, 7'h5B, 7'h3F};
    int se_n = 0;
    clear_errs = 1; step(); clear_errs = 0;
    total++;
    if (err_count !== '0) begin bad++; $display("FAIL sat_clear got=%0d req=0", err_count); end
    for (int p = 0; p < 5; p++) begin
      seg_in = pats[p];
      repeat (12) begin
        step();
        total++;
        if (obs_vec() !== exp_vec()) begin
          bad++; $display("FAIL sat_cycle obs=%h req=%h", obs_vec(), exp_vec());
        end
        log_evt("sat");
        if (seq_err) se_n++;
      end
    end
    total++;
    if (se_n !== 5 || err_count !== W'(3)) begin
      bad++; $display("FAIL sat_value se=%0d err=%0d req se=5 err=3", se_n, err_count);
    end
    // Sixth error lands on the (S+3)th edge after the change; clear on that edge.
    seg_in = 7'h5B;
    repeat (S + 2) step();
    clear_errs = 1;
    step();
    clear_errs = 0;
    total++;
    if (seq_err !== 1'b1 || err_count !== '0) begin
      bad++; $display("FAIL sat_clear_wins se=%0b err=%0d req se=1 err=0", seq_err, err_count);
    end
    total++;
    if (obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL sat_clear_model obs=%h req=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    seg_in = 7'h7D;
    repeat (3) step();
    reset = 1;
    step();
    total++;
    if (obs_vec() !== '0) begin bad++; $display("FAIL midreset_values obs=%h req=0", obs_vec()); end
    reset = 0;
    repeat (S + 1) begin
      step();
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL midreset_cycle obs=%h req=%h", obs_vec(), exp_vec());
      end
      if (digit_valid || code_err || seq_err) pulses++;
    end
    total++;
    if (pulses !== 0) begin bad++; $display("FAIL midreset_pulses got=%0d req=0", pulses); end
    repeat (15) begin
      step();
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL midreset_after obs=%h req=%h", obs_vec(), exp_vec());
      end
      log_evt("midreset");
    end
  endtask

  task automatic test_random();
    logic [6:0] p;
    int hold, r;
    for (int t = 0; t < 60; t++) begin
      r = $urandom_range(0, 9);
      if (r <= 6) begin
        p = seg_tab[$urandom_range(0, 15)];
      end else if (r <= 8) begin
        do p = 7'($urandom_range(1, 127)); while (decode(p) >= 0);
      end else begin
        p = 7'h00;
      end
      hold = $urandom_range(1, 12);
      seg_in = p;
      $display("txn random seg=%h hold=%0d", p, hold);
      repeat (hold) begin
        clear_errs = ($urandom_range(0, 15) == 0);
        step();
        total++;
        if (obs_vec() !== exp_vec()) begin
          bad++; $display("FAIL random_cycle seg=%h obs=%h req=%h", p, obs_vec(), exp_vec());
        end
      end
    end
    clear_errs = 0;
  endtask

  initial begin
    reset = 1; seg_in = 7'h00; clear_errs = 0;
    test_reset();
    test_counting();
    test_wrap();
    test_glitch();
    test_illegal();
    test_blank();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
